uart_tx_fifo_sb_ctrl: RTL and testbench

Parametrised UART transmit controller on the system bus, the successor to the single-byte TX controller. Software pushes characters into a DEPTH-entry FIFO through a memory-mapped register file. An internal serializer drains the FIFO back-to-back with runtime-configurable divisor, parity and stop bits. Status, level, sticky overflow and a completion interrupt replace busy-polling per byte.

---
 rtl/uart_tx_fifo_sb_ctrl_if.sv | 26 ++
 rtl/uart_tx_fifo_sb_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo_sb_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_sb_ctrl_if.sv
// System-bus port bundle for the FIFO-backed UART transmit controller.
// The bus master drives request, direction, address and write data.
// The controller returns combinational read data.
interface uart_tx_fifo_sb_ctrl_if;
    logic        req_i;
    logic        write_enable_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;

    modport master (
        output req_i,
        output write_enable_i,
        output addr_i,
        output write_data_i,
        input  read_data_o
    );

    modport slave (
        input  req_i,
        input  write_enable_i,
        input  addr_i,
        input  write_data_i,
        output read_data_o
    );
endinterface

// File: rtl/uart_tx_fifo_sb_ctrl.sv
// UART transmit controller with a DEPTH-entry character FIFO on the system bus.
// Software pushes characters through a small register file. A serializer drains
// the FIFO back-to-back, using a divisor, parity enable and stop-bit count that
// are latched at the start of each frame.
module uart_tx_fifo_sb_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DIV_W   = 17,
    parameter int unsigned RST_DIV = 5208
) (
    input  logic                   clk_i,
    input  logic                   rst,
    uart_tx_fifo_sb_ctrl_if.slave  bus,
    output logic                   tx_o,
    output logic                   irq_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(RST_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // Register map
    localparam logic [31:0] A_DATA     = 32'h00;
    localparam logic [31:0] A_STATUS   = 32'h04;
    localparam logic [31:0] A_LEVEL    = 32'h08;
    localparam logic [31:0] A_DIVISOR  = 32'h0C;
    localparam logic [31:0] A_PARITY   = 32'h10;
    localparam logic [31:0] A_STOPBITS = 32'h14;
    localparam logic [31:0] A_IRQ_EN   = 32'h18;
    localparam logic [31:0] A_SOFT_RST = 32'h24;

    // Serializer states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Bus decode
    logic w_wr;
    logic w_rd;
    logic w_soft_rst;
    logic w_rst;
    logic w_push;
    logic w_push_ok;
    logic w_pop;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              w_empty;
    logic              w_full;

    // Software-visible configuration
    logic [DIV_W-1:0]  r_div;
    logic              r_par_en;
    logic              r_stop2;
    logic              r_irq_en;
    logic [DATA_W-1:0] r_last;
    logic              w_cfg_ok;

    // Serializer
    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_clk_cnt;
    logic [3:0]        r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_bit;
    logic [DIV_W-1:0]  r_f_div;
    logic              r_f_par;
    logic              r_f_stop2;
    logic              w_busy;
    logic              w_bit_end;
    logic              w_last_stop;
    logic              w_frame_end;

    assign w_wr = bus.req_i & bus.write_enable_i;
    assign w_rd = bus.req_i & ~bus.write_enable_i;

    // A write of exactly 1 to SOFT_RST resets the block on that same edge.
    assign w_soft_rst = w_wr && (bus.addr_i == A_SOFT_RST) && (bus.write_data_i == 32'd1);
    assign w_rst      = rst | w_soft_rst;

    assign w_busy   = (r_state != S_IDLE);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_cfg_ok = ~w_busy & w_empty;

    assign w_bit_end   = (r_clk_cnt == (r_f_div - DIV_ONE));
    assign w_last_stop = (r_bit_cnt == {3'b000, r_f_stop2});
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && w_last_stop;

    // Pop either from idle or at the last stop clock, so frames run back-to-back.
    assign w_pop     = ~w_empty & ((r_state == S_IDLE) | w_frame_end);
    assign w_push    = w_wr && (bus.addr_i == A_DATA);
    assign w_push_ok = w_push & (~w_full | w_pop);

    assign irq_o = r_irq_en & w_empty & ~w_busy;

    // FIFO storage write; contents need no reset since the pointers are cleared
    always_ff @(posedge clk_i) begin
        if (w_push_ok && !w_rst) begin
            r_mem[r_wptr] <= bus.write_data_i[DATA_W-1:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_wr && (bus.addr_i == A_STATUS)) begin
                r_overflow <= 1'b0;
            end else if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Configuration registers; frame parameters only change while fully idle
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_div    <= DIV_RST;
            r_par_en <= 1'b1;
            r_stop2  <= 1'b1;
            r_irq_en <= 1'b0;
            r_last   <= '0;
        end else if (w_wr) begin
            case (bus.addr_i)
                A_DATA:     r_last <= bus.write_data_i[DATA_W-1:0];
                A_DIVISOR:  if (w_cfg_ok) r_div    <= bus.write_data_i[DIV_W-1:0];
                A_PARITY:   if (w_cfg_ok) r_par_en <= bus.write_data_i[0];
                A_STOPBITS: if (w_cfg_ok) r_stop2  <= bus.write_data_i[0];
                A_IRQ_EN:   r_irq_en <= bus.write_data_i[0];
                default:    ;
            endcase
        end
    end

    // Serializer FSM: START, DATA (LSB first), optional even PARITY, 1-2 STOP bits
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_f_div   <= DIV_ONE;
            r_f_par   <= 1'b0;
            r_f_stop2 <= 1'b0;
        end else if (w_pop) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= r_mem[r_rptr];
            r_par_bit <= ^r_mem[r_rptr];
            r_f_div   <= (r_div == '0) ? DIV_ONE : r_div;
            r_f_par   <= r_par_en;
            r_f_stop2 <= r_stop2;
        end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
                r_clk_cnt <= '0;
                case (r_state)
                    S_START: begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                    S_DATA: begin
                        r_shift <= {1'b0, r_shift[DATA_W-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state   <= r_f_par ? S_PARITY : S_STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        r_state   <= S_STOP;
                        r_bit_cnt <= '0;
                    end
                    S_STOP: begin
                        if (w_last_stop) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else begin
                r_clk_cnt <= r_clk_cnt + DIV_ONE;
            end
        end
    end

    // Serial line level for the current state
    always_comb begin
        tx_o = 1'b1;
        case (r_state)
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = r_shift[0];
            S_PARITY: tx_o = r_par_bit;
            default:  tx_o = 1'b1;
        endcase
    end

    // Combinational register readback, zero outside reads and unmapped addresses
    always_comb begin
        bus.read_data_o = '0;
        if (w_rd) begin
            case (bus.addr_i)
                A_DATA:     bus.read_data_o = 32'(r_last);
                A_STATUS:   bus.read_data_o = {28'd0, r_overflow, w_empty, w_full, w_busy};
                A_LEVEL:    bus.read_data_o = 32'(r_count);
                A_DIVISOR:  bus.read_data_o = 32'(r_div);
                A_PARITY:   bus.read_data_o = {31'd0, r_par_en};
                A_STOPBITS: bus.read_data_o = {31'd0, r_stop2};
                A_IRQ_EN:   bus.read_data_o = {31'd0, r_irq_en};
                default:    bus.read_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_sb_ctrl.sv
// Bench for uart_tx_fifo_sb_ctrl: register vector table, exact frame waveform,
// config lock, burst, overflow and soft reset sequences, with a serial
// receiver that checks decoded characters against a scoreboard queue.
module tb_uart_tx_fifo_sb_ctrl;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 8;

    logic clk_i = 1'b0;
    logic rst;
    logic tx_o;
    logic irq_o;

    uart_tx_fifo_sb_ctrl_if bus ();

    uart_tx_fifo_sb_ctrl #(
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .DIV_W   (17),
        .RST_DIV (5208)
    ) dut (
        .clk_i (clk_i),
        .rst   (rst),
        .bus   (bus),
        .tx_o  (tx_o),
        .irq_o (irq_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    logic        mon_en    = 1'b0;
    int unsigned mon_div   = 4;
    logic        mon_par   = 1'b1;
    logic        mon_stop2 = 1'b1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd_seen);
        @(negedge clk_i);
        bus.req_i          = 1'b1;
        bus.write_enable_i = 1'b1;
        bus.addr_i         = a;
        bus.write_data_i   = d;
        #1 rd_seen = bus.read_data_o;
        @(posedge clk_i);
        #1;
        bus.req_i          = 1'b0;
        bus.write_enable_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_write(a, d, dummy);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.req_i          = 1'b1;
        bus.write_enable_i = 1'b0;
        bus.addr_i         = a;
        #1 d = bus.read_data_o;
        bus.req_i          = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_to(input int unsigned t);
        while (cyc < t) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        bus.req_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk_i);
        rst = 1'b0;
    endtask

    // Serial receiver: samples mid-bit on falling clock edges
    initial begin
        int unsigned d;
        logic [7:0]  v;
        logic        avail;
        forever begin
            @(negedge clk_i);
            if (mon_en && tx_o === 1'b0) begin
                start_q.push_back(cyc);
                d = mon_div;
                repeat (d / 2) @(negedge clk_i);
                check("rx_start_bit", tx_o, 1'b0);
                for (int b = 0; b < DATA_W; b++) begin
                    repeat (d) @(negedge clk_i);
                    v[b] = tx_o;
                end
                if (mon_par) begin
                    repeat (d) @(negedge clk_i);
                    check("rx_parity", tx_o, ^v);
                end
                repeat (d) @(negedge clk_i);
                check("rx_stop1", tx_o, 1'b1);
                if (mon_stop2) begin
                    repeat (d) @(negedge clk_i);
                    check("rx_stop2", tx_o, 1'b1);
                end
                avail = (exp_q.size() != 0);
                check("rx_expected_avail", avail, 1'b1);
                if (avail) check("rx_byte", v, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [11:0] fr;
        int unsigned c0;
        logic        done;
        int          m_cnt;
        logic        m_busy;
        logic        m_ovf;
        logic        m_pop;
        logic        m_acc;

        vecs[0]  = '{1'b0, 32'h0C, 32'h0,        32'd5208,     1'b0};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        32'd1,        1'b0};
        vecs[2]  = '{1'b0, 32'h14, 32'h0,        32'd1,        1'b0};
        vecs[3]  = '{1'b0, 32'h04, 32'h0,        32'h4,        1'b0};
        vecs[4]  = '{1'b0, 32'h18, 32'h0,        32'd0,        1'b0};
        vecs[5]  = '{1'b0, 32'h08, 32'h0,        32'd0,        1'b0};
        vecs[6]  = '{1'b0, 32'h00, 32'h0,        32'd0,        1'b0};
        vecs[7]  = '{1'b0, 32'h20, 32'h0,        32'd0,        1'b0};
        vecs[8]  = '{1'b0, 32'h24, 32'h0,        32'd0,        1'b0};
        vecs[9]  = '{1'b1, 32'h0C, 32'd4,        32'd0,        1'b0};
        vecs[10] = '{1'b0, 32'h0C, 32'h0,        32'd4,        1'b0};
        vecs[11] = '{1'b1, 32'h10, 32'hFFFFFFFE, 32'd0,        1'b0};
        vecs[12] = '{1'b0, 32'h10, 32'h0,        32'd0,        1'b0};
        vecs[13] = '{1'b1, 32'h14, 32'd3,        32'd0,        1'b0};
        vecs[14] = '{1'b0, 32'h14, 32'h0,        32'd1,        1'b0};
        vecs[15] = '{1'b1, 32'h18, 32'd1,        32'd0,        1'b1};
        vecs[16] = '{1'b0, 32'h18, 32'h0,        32'd1,        1'b1};
        vecs[17] = '{1'b1, 32'h24, 32'd2,        32'd0,        1'b1};
        vecs[18] = '{1'b0, 32'h0C, 32'h0,        32'd4,        1'b1};
        vecs[19] = '{1'b1, 32'h24, 32'd1,        32'd0,        1'b0};
        vecs[20] = '{1'b0, 32'h0C, 32'h0,        32'd5208,     1'b0};
        vecs[21] = '{1'b0, 32'h10, 32'h0,        32'd1,        1'b0};
        vecs[22] = '{1'b0, 32'h14, 32'h0,        32'd1,        1'b0};
        vecs[23] = '{1'b0, 32'h18, 32'h0,        32'd0,        1'b0};
        vecs[24] = '{1'b1, 32'h0C, 32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[25] = '{1'b0, 32'h0C, 32'h0,        32'h1FFFF,    1'b0};

        bus.req_i          = 1'b0;
        bus.write_enable_i = 1'b0;
        bus.addr_i         = '0;
        bus.write_data_i   = '0;
        rst                = 1'b1;
        repeat (3) @(negedge clk_i);
        rst = 1'b0;
        check("reset_tx", tx_o, 1'b1);
        check("reset_irq", irq_o, 1'b0);

        // Register vector table, idle with an empty FIFO
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wdata, d);
            end else begin
                @(negedge clk_i);
                bus_read(vecs[i].addr, d);
            end
            check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), irq_o, vecs[i].exp_irq);
            check($sformatf("vec%0d_tx", i), tx_o, 1'b1);
        end

        // Single frame: divisor 4, even parity, two stop bits, 0xA5
        do_reset();
        wr(32'h0C, 32'd4);
        mon_div = 4; mon_par = 1'b1; mon_stop2 = 1'b1; mon_en = 1'b1;
        exp_q.push_back(8'hA5);
        wr(32'h00, 32'hA5);
        rd_check("single_level_after_push", 32'h08, 32'd1);
        rd_check("single_status_after_push", 32'h04, 32'h0);
        rd_check("single_data_readback", 32'h00, 32'hA5);
        fr = {2'b11, 1'b0, 8'hA5, 1'b0};
        @(posedge clk_i);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk_i);
            check($sformatf("single_tx_clk%0d", k), tx_o, fr[k / 4]);
        end
        rd_check("single_busy_last_clk", 32'h04, 32'h5);
        @(negedge clk_i);
        rd_check("single_idle_after", 32'h04, 32'h4);
        check("single_tx_idle", tx_o, 1'b1);
        check("single_irq_disabled", irq_o, 1'b0);

        // Config writes while busy are ignored and do not disturb the frame
        exp_q.push_back(8'h3C);
        wr(32'h00, 32'h3C);
        c0 = cyc;
        wait_to(c0 + 10);
        wr(32'h0C, 32'd8);
        rd_check("lock_divisor", 32'h0C, 32'd4);
        wr(32'h10, 32'd0);
        rd_check("lock_parity", 32'h10, 32'd1);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            bus_read(32'h04, d);
            if (d[0] == 1'b0) done = 1'b1;
        end
        check("lock_done_in_time", done, 1'b1);
        check("lock_frame_len", cyc - c0, 32'd49);
        check("lock_rx_drained", exp_q.size(), 32'd0);

        // Burst of three: divisor 2, no parity, one stop bit
        wr(32'h0C, 32'd2);
        wr(32'h10, 32'd0);
        wr(32'h14, 32'd0);
        wr(32'h18, 32'd1);
        mon_div = 2; mon_par = 1'b0; mon_stop2 = 1'b0;
        start_q.delete();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        wr(32'h00, 32'h11);
        c0 = cyc;
        wr(32'h00, 32'h22);
        wr(32'h00, 32'h33);
        rd_check("burst_level_2_early", 32'h08, 32'd2);
        check("burst_irq_busy", irq_o, 1'b0);
        wait_to(c0 + 20);
        rd_check("burst_level_2", 32'h08, 32'd2);
        wait_to(c0 + 21);
        rd_check("burst_level_1", 32'h08, 32'd1);
        wait_to(c0 + 41);
        rd_check("burst_level_0", 32'h08, 32'd0);
        wait_to(c0 + 60);
        check("burst_irq_last_stop", irq_o, 1'b0);
        rd_check("burst_status_last_stop", 32'h04, 32'h5);
        wait_to(c0 + 61);
        check("burst_irq_done", irq_o, 1'b1);
        rd_check("burst_status_done", 32'h04, 32'h4);
        check("burst_frames", start_q.size(), 32'd3);
        if (start_q.size() == 3) begin
            check("burst_first_start", start_q[0], c0 + 1);
            check("burst_gap_1", start_q[1] - start_q[0], 32'd20);
            check("burst_gap_2", start_q[2] - start_q[1], 32'd20);
        end
        check("burst_rx_drained", exp_q.size(), 32'd0);

        // Overflow: DEPTH+2 pushes against a slow serializer
        do_reset();
        wr(32'h0C, 32'd8);
        wr(32'h10, 32'd0);
        wr(32'h14, 32'd0);
        mon_div = 8; mon_par = 1'b0; mon_stop2 = 1'b0;
        m_cnt = 0; m_busy = 1'b0; m_ovf = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            m_pop = !m_busy && (m_cnt > 0);
            m_acc = (m_cnt < DEPTH) || m_pop;
            m_cnt = m_cnt + int'(m_acc) - int'(m_pop);
            if (m_pop) m_busy = 1'b1;
            if (!m_acc) m_ovf = 1'b1;
            if (m_acc) exp_q.push_back(8'h40 + 8'(k));
            wr(32'h00, 32'h40 + k);
            if (k == 0) c0 = cyc;
        end
        rd_check("ovf_status", 32'h04, {28'd0, m_ovf, m_cnt == 0, m_cnt == DEPTH, m_busy});
        rd_check("ovf_level", 32'h08, m_cnt);
        wr(32'h04, 32'd0);
        rd_check("ovf_cleared", 32'h04, 32'h3);
        // Push exactly on the edge where the first frame ends and pops
        wait_to(c0 + 79);
        exp_q.push_back(8'h7E);
        wr(32'h00, 32'h7E);
        rd_check("fullpop_level", 32'h08, 32'd16);
        rd_check("fullpop_status", 32'h04, 32'h3);
        done = 1'b0;
        for (int i = 0; i < 2500 && !done; i++) begin
            @(negedge clk_i);
            bus_read(32'h04, d);
            if (d == 32'h4 && exp_q.size() == 0) done = 1'b1;
        end
        check("ovf_drain_in_time", done, 1'b1);
        repeat (100) @(negedge clk_i);
        check("ovf_all_sent", exp_q.size(), 32'd0);
        rd_check("ovf_final_status", 32'h04, 32'h4);

        // Soft reset in the middle of a data bit
        do_reset();
        wr(32'h0C, 32'd4);
        mon_en = 1'b0;
        wr(32'h00, 32'h5A);
        c0 = cyc;
        wr(32'h00, 32'h77);
        wr(32'h24, 32'd2);
        rd_check("srst2_level", 32'h08, 32'd1);
        rd_check("srst2_divisor", 32'h0C, 32'd4);
        rd_check("srst2_busy", 32'h04, 32'h1);
        wait_to(c0 + 5);
        check("srst_pre_tx", tx_o, 1'b0);
        wr(32'h24, 32'd1);
        check("srst_tx_high", tx_o, 1'b1);
        check("srst_irq", irq_o, 1'b0);
        rd_check("srst_level", 32'h08, 32'd0);
        rd_check("srst_status", 32'h04, 32'h4);
        rd_check("srst_divisor", 32'h0C, 32'd5208);
        rd_check("srst_parity", 32'h10, 32'd1);
        rd_check("srst_stopbits", 32'h14, 32'd1);
        rd_check("srst_irq_en", 32'h18, 32'd0);
        rd_check("srst_data", 32'h00, 32'd0);
        repeat (40) @(negedge clk_i);
        check("srst_tx_stays_high", tx_o, 1'b1);
        rd_check("srst_stays_idle", 32'h04, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
